// File: rtl/dsp_pass_scheduler_pkg.sv
// dsp_pass_scheduler_pkg: shared state encoding, widths and shift/saturation helpers
package dsp_pass_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, EMIT} state_t;
  localparam int DSP_RESULT_W = 48;
  localparam int OUT_W_DEF = 18;
  localparam logic [5:0] SHIFT_MAX = 6'd47;
  function automatic logic [5:0] clamp_shift(input logic [5:0] s);
    return (s > SHIFT_MAX) ? SHIFT_MAX : s;
  endfunction
  // {over, under} against the signed range of a w-bit word
  function automatic logic [1:0] sat_flags(input logic signed [DSP_RESULT_W-1:0] v, input int w);
    logic signed [DSP_RESULT_W-1:0] hi;
    hi = $signed({DSP_RESULT_W{1'b1}} >> (DSP_RESULT_W - w + 1));
    return {v > hi, v < ~hi};
  endfunction
endpackage

// File: rtl/dsp_pass_scheduler_result_saturator.sv
// dsp_pass_scheduler_result_saturator: arithmetic right shift of a 48-bit result, saturated to OUT_W bits
module dsp_pass_scheduler_result_saturator
  import dsp_pass_scheduler_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [DSP_RESULT_W-1:0] din,
  input  logic [5:0]              shift,
  output logic [OUT_W-1:0]        dout
);
  logic signed [DSP_RESULT_W-1:0] v;
  logic [1:0] f;
  always_comb begin
    v = $signed(din) >>> shift;
    f = sat_flags(v, OUT_W);
    dout = f[1] ? {1'b0, {(OUT_W-1){1'b1}}} : f[0] ? {1'b1, {(OUT_W-1){1'b0}}} : v[OUT_W-1:0];
  end
endmodule

// File: rtl/dsp_pass_scheduler.sv
// dsp_pass_scheduler: runs clear/run/emit passes on the DSP controller and streams saturated results
module dsp_pass_scheduler
  import dsp_pass_scheduler_pkg::*;
#(
  parameter int OUT_W          = OUT_W_DEF,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_pass_count,
  input  logic [12:0]             cmd_filter_length,
  input  logic [5:0]              cmd_shift,
  output logic                    dsp_rst,
  output logic [12:0]             filter_length,
  input  logic [DSP_RESULT_W-1:0] dsp_result,
  input  logic                    dsp_result_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [7:0]              pass_index,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err
);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state, next;
  logic [CW-1:0] clr_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0] pass_count;
  logic [5:0] shift;
  logic [OUT_W-1:0] sat;
  logic accept, ready_hit, timed_out, hs, last;
  dsp_pass_scheduler_result_saturator #(.OUT_W(OUT_W)) result_saturator (
    .din(dsp_result), .shift(shift), .dout(sat)
  );
  // Outputs decode straight from state so an async reset takes effect at once
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign dsp_rst   = state != RUN;
  assign out_valid = state == EMIT;
  assign accept    = cmd_valid && cmd_ready;
  assign ready_hit = state == RUN && dsp_result_ready;
  assign timed_out = state == RUN && !dsp_result_ready && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign hs        = state == EMIT && out_ready;
  assign last      = hs && (pass_index + 8'd1) == pass_count;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = (accept && cmd_pass_count != 8'd0) ? CLEAR : IDLE;
      CLEAR:   next = (clr_cnt == '0) ? RUN : CLEAR;
      RUN:     next = dsp_result_ready ? EMIT : timed_out ? IDLE : RUN;
      EMIT:    next = !out_ready ? EMIT : last ? IDLE : CLEAR;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      clr_cnt       <= '0;
      to_cnt        <= '0;
      pass_count    <= '0;
      filter_length <= '0;
      shift         <= '0;
      pass_index    <= '0;
      out_data      <= '0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state   <= next;
      done    <= (accept && cmd_pass_count == 8'd0) || last;
      clr_cnt <= (state == CLEAR) ? clr_cnt - 1'b1 : CW'(CLEAR_CYCLES - 1);
      to_cnt  <= (state == RUN) ? to_cnt + 1'b1 : '0;
      if (accept) begin
        pass_count    <= cmd_pass_count;
        filter_length <= cmd_filter_length;
        shift         <= clamp_shift(cmd_shift);
        pass_index    <= '0;
        timeout_err   <= 1'b0;
      end
      if (timed_out) timeout_err <= 1'b1;
      if (ready_hit) out_data <= sat;
      if (hs) pass_index <= pass_index + 8'd1;
    end
  end
endmodule

// File: tb/tb_dsp_pass_scheduler.sv
// tb_dsp_pass_scheduler: directed checks of pass sequencing, saturation, timeout and async reset
module tb_dsp_pass_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [7:0] cmd_pass_count = '0;
  logic [12:0] cmd_filter_length = '0;
  logic [5:0] cmd_shift = '0;
  logic dsp_rst;
  logic [12:0] filter_length;
  logic [47:0] dsp_result = '0;
  logic dsp_result_ready = 1'b0;
  logic out_valid, out_ready = 1'b1;
  logic [17:0] out_data;
  logic [7:0] pass_index;
  logic busy, done, timeout_err;
  int total = 0, bad = 0, words = 0, n;

  dsp_pass_scheduler dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pass_count(cmd_pass_count), .cmd_filter_length(cmd_filter_length), .cmd_shift(cmd_shift),
    .dsp_rst(dsp_rst), .filter_length(filter_length), .dsp_result(dsp_result),
    .dsp_result_ready(dsp_result_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .pass_index(pass_index), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (out_valid && out_ready) words++;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] pc, input logic [12:0] fl, input logic [5:0] sh);
    cmd_pass_count = pc;
    cmd_filter_length = fl;
    cmd_shift = sh;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic clear_check(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_clr"}, dsp_rst, 1'b1);
      tick;
    end
    chk({tag, "_run"}, dsp_rst, 1'b0);
  endtask

  task automatic give(input logic [47:0] r, input int cyc);
    for (int i = 0; i < cyc - 1; i++) tick;
    dsp_result = r;
    dsp_result_ready = 1'b1;
    tick;
    dsp_result_ready = 1'b0;
  endtask

  task automatic single(input string tag, input logic [47:0] r, input logic [5:0] sh, input logic [17:0] exp);
    start(8'd1, 13'd5, sh);
    clear_check(tag);
    give(r, 1);
    chk({tag, "_data"}, out_data, exp);
    tick;
    chk({tag, "_done"}, done, 1'b1);
    tick;
  endtask

  initial begin
    #1;
    chk("rst_dsp_rst", dsp_rst, 1'b1);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 18'h0);
    chk("rst_fl", filter_length, 13'h0);
    chk("rst_pidx", pass_index, 8'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick;

    start(8'd1, 13'd9, 6'd0);
    chk("p1_fl", filter_length, 13'd9);
    chk("p1_busy", busy, 1'b1);
    clear_check("p1");
    give(48'd1234, 20);
    chk("p1_valid", out_valid, 1'b1);
    chk("p1_data", out_data, 18'd1234);
    chk("p1_emit_rst", dsp_rst, 1'b1);
    tick;
    chk("p1_done", done, 1'b1);
    chk("p1_pidx", pass_index, 8'd1);
    chk("p1_valid_off", out_valid, 1'b0);
    chk("p1_cmd_ready", cmd_ready, 1'b1);
    tick;
    chk("p1_done_off", done, 1'b0);
    chk("p1_words", words, 1);

    single("sat_pos", 48'h0000_4000_0000, 6'd4, 18'h1FFFF);
    single("sat_neg", 48'hFFFF_C000_0000, 6'd4, 18'h20000);
    single("neg_small", 48'hFFFF_FFFF_FFF8, 6'd2, 18'h3FFFE);
    single("clamp60", 48'h4000_0000_0000, 6'd60, 18'h0);
    single("s47_min", 48'h8000_0000_0000, 6'd47, 18'h3FFFF);
    single("edge_max", 48'd131071, 6'd0, 18'h1FFFF);
    single("edge_over", 48'd131072, 6'd0, 18'h1FFFF);
    single("edge_min", 48'hFFFF_FFFE_0000, 6'd0, 18'h20000);
    single("edge_under", 48'hFFFF_FFFD_FFFF, 6'd0, 18'h20000);

    words = 0;
    start(8'd3, 13'd7, 6'd0);
    clear_check("m1");
    give(48'd100, 3);
    chk("m1_data", out_data, 18'd100);
    tick;
    chk("m1_pidx", pass_index, 8'd1);
    clear_check("m2");
    out_ready = 1'b0;
    give(48'd200, 2);
    for (int i = 0; i < 10; i++) begin
      chk("m2_stall_valid", out_valid, 1'b1);
      chk("m2_stall_data", out_data, 18'd200);
      tick;
    end
    out_ready = 1'b1;
    tick;
    chk("m2_pidx", pass_index, 8'd2);
    chk("m2_no_done", done, 1'b0);
    clear_check("m3");
    give(-48'sd300, 1);
    chk("m3_data", out_data, 18'h3FED4);
    tick;
    chk("m3_done", done, 1'b1);
    chk("m3_pidx", pass_index, 8'd3);
    chk("m_words", words, 3);
    tick;

    words = 0;
    start(8'd1, 13'd3, 6'd0);
    clear_check("to");
    n = 0;
    while (dsp_rst == 1'b0 && n < 5000) begin
      if (done) chk("to_no_done", done, 1'b0);
      n++;
      tick;
    end
    chk("to_cycles", n, 4096);
    chk("to_err", timeout_err, 1'b1);
    chk("to_idle", cmd_ready, 1'b1);
    chk("to_done", done, 1'b0);
    chk("to_words", words, 0);

    start(8'd0, 13'd1, 6'd0);
    chk("z_done", done, 1'b1);
    chk("z_err_clr", timeout_err, 1'b0);
    chk("z_dsp_rst", dsp_rst, 1'b1);
    chk("z_busy", busy, 1'b0);
    chk("z_valid", out_valid, 1'b0);
    tick;
    chk("z_done_off", done, 1'b0);

    start(8'd1, 13'd11, 6'd0);
    cmd_pass_count = 8'd5;
    cmd_filter_length = 13'd99;
    cmd_valid = 1'b1;
    chk("bz_ready", cmd_ready, 1'b0);
    tick;
    chk("bz_fl", filter_length, 13'd11);
    cmd_valid = 1'b0;
    tick;
    give(48'd42, 1);
    tick;
    chk("bz_done", done, 1'b1);
    chk("bz_pidx", pass_index, 8'd1);
    tick;

    start(8'd2, 13'd8, 6'd0);
    clear_check("ar1");
    #2 rst = 1'b1;
    #1;
    chk("ar1_dsp_rst", dsp_rst, 1'b1);
    chk("ar1_busy", busy, 1'b0);
    chk("ar1_fl", filter_length, 13'd0);
    #1 rst = 1'b0;
    tick;
    start(8'd1, 13'd8, 6'd0);
    clear_check("ar2");
    out_ready = 1'b0;
    give(48'd555, 1);
    chk("ar2_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar2_valid_off", out_valid, 1'b0);
    chk("ar2_data", out_data, 18'd0);
    chk("ar2_ready", cmd_ready, 1'b1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    tick;
    single("after_rst", 48'd777, 6'd0, 18'd777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
